fetch_unit: RTL and testbench

- Instruction-fetch stage of the 5-stage RISC-V pipeline.
- Owns the PC and an instruction-memory request/acknowledge handshake, and drives the IF/ID pipeline register.
- Consumes the stall controls from the hazard detection unit (PCWrite, IF_ID_Write) and the branch redirect/flush from the ID stage.
- Delivers {pc, instr, valid} to the decode stage.

---
 rtl/pipeline_pkg.sv | 24 ++
 rtl/fetch_unit_if.sv | 22 ++
 rtl/fetch_unit_if_id_register.sv | 23 ++
 rtl/fetch_unit.sv | 162 ++++++++++++++++
 tb/tb_fetch_unit.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline types and constants for the instruction-fetch stage.
package pipeline_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

  // IF/ID pipeline register payload.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            valid;
  } if_id_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return a & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory handshake and IF/ID delivery bundle of the fetch stage.
interface fetch_unit_if;

  logic                         imem_req_o;
  logic [pipeline_pkg::XLEN-1:0] imem_addr_o;
  logic                         imem_ack_i;
  logic [pipeline_pkg::XLEN-1:0] imem_rdata_i;
  logic [pipeline_pkg::XLEN-1:0] IF_ID_pc_o;
  logic [pipeline_pkg::XLEN-1:0] IF_ID_instr_o;
  logic                         IF_ID_valid_o;

  modport master (
    output imem_req_o, imem_addr_o, IF_ID_pc_o, IF_ID_instr_o, IF_ID_valid_o,
    input  imem_ack_i, imem_rdata_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o, IF_ID_pc_o, IF_ID_instr_o, IF_ID_valid_o,
    output imem_ack_i, imem_rdata_i
  );

endinterface

// File: rtl/fetch_unit_if_id_register.sv
// IF/ID pipeline register: write-enabled load, flush dominant, resets to a bubble.
module if_id_register
  import pipeline_pkg::*;
#(
  parameter logic [XLEN-1:0] BUBBLE_INSTR = 32'h0000_0013
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   we,
  input  logic   flush,
  input  if_id_t d,
  output if_id_t q
);

  always_ff @(posedge clk_i) begin
    if (rst_i || flush) begin
      q <= '{pc: '0, instr: BUBBLE_INSTR, valid: 1'b0};
    end else if (we) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, the imem request/ack handshake and the IF/ID register.
// Optional build macro FETCH_PERF_EN adds fetch and stall counters.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          PCWrite_i,
  input  logic                          IF_ID_Write_i,
  input  logic                          Flush_i,
  input  logic [pipeline_pkg::XLEN-1:0] branch_target_i,
  fetch_unit_if.master                  bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]                   fetch_cnt_o,
  output logic [31:0]                   stall_cnt_o
`endif
);

  import pipeline_pkg::*;

  localparam logic [XLEN-1:0] BOOT_PC = RESET_PC & ~XLEN'(3);

  fetch_state_e    state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] req_addr_q;
  logic [XLEN-1:0] hold_buf_q;
  logic            req_q;
  logic            discard_q;
  logic            buf_valid_q;

  logic            ack_c;
  logic            advance_c;
  logic            deliver_c;
  logic            bubble_c;
  logic [XLEN-1:0] target_c;
  logic [XLEN-1:0] pc_inc_c;
  if_id_t          if_id_d_c;
  if_id_t          if_id_q;

  // An ack only counts against a request we are actually presenting.
  assign ack_c     = bus.imem_ack_i && req_q;
  assign advance_c = PCWrite_i && IF_ID_Write_i && !Flush_i;
  assign target_c  = word_align(branch_target_i);
  assign pc_inc_c  = pc_q + XLEN'(4);

  // IF/ID write decision: deliver a real instruction, insert a bubble, or hold.
  always_comb begin
    deliver_c = 1'b0;
    if_id_d_c = '{pc: req_addr_q, instr: bus.imem_rdata_i, valid: 1'b1};
    case (state_q)
      FETCH: deliver_c = advance_c && ack_c && !discard_q;
      HOLD: begin
        deliver_c = advance_c && buf_valid_q;
        if_id_d_c = '{pc: pc_q, instr: hold_buf_q, valid: 1'b1};
      end
      default: deliver_c = 1'b0;
    endcase
    bubble_c = (state_q != BOOT) && (Flush_i || (IF_ID_Write_i && !deliver_c));
  end

  // Fetch FSM with registered request outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= BOOT;
      pc_q        <= BOOT_PC;
      req_addr_q  <= BOOT_PC;
      hold_buf_q  <= NOP_INSTR;
      req_q       <= 1'b0;
      discard_q   <= 1'b0;
      buf_valid_q <= 1'b0;
    end else begin
      case (state_q)
        BOOT: begin
          state_q    <= FETCH;
          req_q      <= 1'b1;
          req_addr_q <= pc_q;
        end
        FETCH: begin
          if (Flush_i) begin
            pc_q <= target_c;
            // Memory cannot cancel: an unacked request finishes at the old address.
            if (ack_c) begin
              req_addr_q <= target_c;
              discard_q  <= 1'b0;
            end else begin
              discard_q  <= 1'b1;
            end
          end else if (ack_c) begin
            if (discard_q) begin
              discard_q  <= 1'b0;
              req_addr_q <= pc_q;
            end else if (PCWrite_i && IF_ID_Write_i) begin
              pc_q       <= pc_inc_c;
              req_addr_q <= pc_inc_c;
            end else begin
              hold_buf_q  <= bus.imem_rdata_i;
              buf_valid_q <= 1'b1;
              req_q       <= 1'b0;
              state_q     <= HOLD;
            end
          end
        end
        HOLD: begin
          if (Flush_i) begin
            pc_q        <= target_c;
            req_addr_q  <= target_c;
            buf_valid_q <= 1'b0;
            req_q       <= 1'b1;
            state_q     <= FETCH;
          end else if (deliver_c) begin
            pc_q        <= pc_inc_c;
            req_addr_q  <= pc_inc_c;
            buf_valid_q <= 1'b0;
            req_q       <= 1'b1;
            state_q     <= FETCH;
          end
        end
        default: begin
          state_q <= BOOT;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  if_id_register #(
    .BUBBLE_INSTR(NOP_INSTR)
  ) u_if_id (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .we    (deliver_c),
    .flush (bubble_c),
    .d     (if_id_d_c),
    .q     (if_id_q)
  );

  assign bus.imem_req_o    = req_q;
  assign bus.imem_addr_o   = req_addr_q;
  assign bus.IF_ID_pc_o    = if_id_q.pc;
  assign bus.IF_ID_instr_o = if_id_q.instr;
  assign bus.IF_ID_valid_o = if_id_q.valid;

`ifdef FETCH_PERF_EN
  // Counts delivered instructions and stalled cycles outside BOOT; both wrap.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_cnt_o <= '0;
      stall_cnt_o <= '0;
    end else begin
      if (deliver_c) begin
        fetch_cnt_o <= fetch_cnt_o + 32'd1;
      end
      if ((state_q != BOOT) && !(PCWrite_i && IF_ID_Write_i)) begin
        stall_cnt_o <= stall_cnt_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a transaction-level fetch model predicts each cycle's outputs.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFFC;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, pw, iw, fl;
  logic [31:0] tgt;

  fetch_unit_if bus();

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt, stall_cnt;
`endif

  fetch_unit #(
    .RESET_PC (RST_PC),
    .NOP_INSTR(NOP)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .PCWrite_i      (pw),
    .IF_ID_Write_i  (iw),
    .Flush_i        (fl),
    .branch_target_i(tgt),
    .bus            (bus)
`ifdef FETCH_PERF_EN
    ,
    .fetch_cnt_o    (fetch_cnt),
    .stall_cnt_o    (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          req;
    logic [31:0] addr;
    bit          valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] fcnt;
    logic [31:0] scnt;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: program-order PC, one outstanding memory fetch, one parked word.
  bit          m_live, m_boot, m_parked, m_stale;
  logic [31:0] m_pc, m_addr, m_park;
  int          m_wait, lat_mode;
  bit          e_valid;
  logic [31:0] e_pc, e_instr;
  logic [31:0] m_fcnt, m_scnt;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic bit m_fetching();
    return m_live && !m_boot && !m_parked;
  endfunction

  task automatic new_req(input logic [31:0] a);
    m_addr = a;
    m_wait = (lat_mode < 0) ? int'($urandom_range(3, 0)) : lat_mode;
  endtask

  task automatic bubble();
    e_valid = 1'b0;
    e_pc    = '0;
    e_instr = NOP;
  endtask

  task automatic deliver(input logic [31:0] p, input logic [31:0] w);
    e_valid = 1'b1;
    e_pc    = p;
    e_instr = w;
    m_fcnt  = m_fcnt + 32'd1;
  endtask

  task automatic model_step(input bit r, input bit p, input bit w, input bit f,
                            input logic [31:0] t, input bit a);
    bit got;
    got = m_fetching() && a;
    if (r) begin
      m_live = 1'b1; m_boot = 1'b1; m_parked = 1'b0; m_stale = 1'b0;
      m_pc = RST_PC; m_addr = RST_PC; m_fcnt = '0; m_scnt = '0;
      bubble();
      return;
    end
    if (!m_live) return;
    if (m_boot) begin
      m_boot = 1'b0;
      new_req(m_pc);
      return;
    end
    if (!(p && w)) m_scnt = m_scnt + 32'd1;
    if (m_fetching() && !a && m_wait > 0) m_wait--;
    if (f) begin
      bubble();
      m_pc = {t[31:2], 2'b00};
      if (m_parked) begin
        m_parked = 1'b0;
        new_req(m_pc);
      end else if (got) begin
        m_stale = 1'b0;
        new_req(m_pc);
      end else begin
        m_stale = 1'b1;
      end
    end else if (m_parked) begin
      if (p && w) begin
        deliver(m_pc, m_park);
        m_parked = 1'b0;
        m_pc = m_pc + 32'd4;
        new_req(m_pc);
      end else if (w) begin
        bubble();
      end
    end else if (got && m_stale) begin
      m_stale = 1'b0;
      new_req(m_pc);
      if (w) bubble();
    end else if (got && p && w) begin
      deliver(m_addr, mem_word(m_addr));
      m_pc = m_pc + 32'd4;
      new_req(m_pc);
    end else if (got) begin
      m_parked = 1'b1;
      m_park   = mem_word(m_addr);
      if (w) bubble();
    end else if (w) begin
      bubble();
    end
  endtask

  // One clock of stimulus: record what the DUT should show now, then drive the next edge.
  task automatic cycle(input bit r, input bit p, input bit w, input bit f, input logic [31:0] t);
    exp_t e;
    bit   a;
    if (m_live) begin
      e.req = m_fetching(); e.addr = m_addr; e.valid = e_valid;
      e.pc = e_pc; e.instr = e_instr; e.fcnt = m_fcnt; e.scnt = m_scnt;
      sb.push_back(e);
    end
    a = m_fetching() ? (m_wait == 0) : 1'($urandom_range(1, 0));
    rst = r; pw = p; iw = w; fl = f; tgt = t;
    bus.imem_ack_i   = a;
    bus.imem_rdata_i = (a && m_fetching()) ? mem_word(m_addr) : $urandom();
    model_step(r, p, w, f, t, a);
    @(negedge clk);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: compares the DUT against the oldest expectation each cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("imem_req", 32'(bus.imem_req_o), 32'(e.req));
        if (e.req) check("imem_addr", bus.imem_addr_o, e.addr);
        check("if_id_valid", 32'(bus.IF_ID_valid_o), 32'(e.valid));
        check("if_id_pc", bus.IF_ID_pc_o, e.pc);
        check("if_id_instr", bus.IF_ID_instr_o, e.instr);
`ifdef FETCH_PERF_EN
        check("fetch_cnt", fetch_cnt, e.fcnt);
        check("stall_cnt", stall_cnt, e.scnt);
`endif
      end
    end
  end

  initial begin
    bit          r, p, w, f;
    logic [31:0] t;
    rst = 1'b1; pw = 1'b1; iw = 1'b1; fl = 1'b0; tgt = '0;
    bus.imem_ack_i = 1'b0; bus.imem_rdata_i = '0;
    m_live = 1'b0; m_boot = 1'b0; m_parked = 1'b0; m_stale = 1'b0;
    m_pc = '0; m_addr = '0; m_park = '0; m_wait = 0; lat_mode = 0;
    e_valid = 1'b0; e_pc = '0; e_instr = NOP; m_fcnt = '0; m_scnt = '0;
    @(negedge clk);

    // Reset, then back-to-back same-cycle acks crossing the address wrap.
    cycle(1, 1, 1, 0, '0);
    cycle(1, 1, 1, 0, '0);
    repeat (5) cycle(0, 1, 1, 0, '0);

    // Two-cycle load-use stall parks the acked word, then release.
    cycle(0, 0, 0, 0, '0);
    cycle(0, 0, 0, 0, '0);
    repeat (3) cycle(0, 1, 1, 0, '0);

    // Flush while a slow fetch is outstanding: old address held, data dropped.
    lat_mode = 3;
    cycle(0, 1, 1, 0, '0);
    cycle(0, 1, 1, 1, 32'h0000_0100);
    lat_mode = 0;
    repeat (6) cycle(0, 1, 1, 0, '0);

    // Redirect to a misaligned target during a PC stall.
    cycle(0, 0, 1, 1, 32'h0000_0203);
    repeat (3) cycle(0, 1, 1, 0, '0);

    // Reset in the middle of a long-latency fetch.
    lat_mode = 4;
    repeat (3) cycle(0, 1, 1, 0, '0);
    lat_mode = 0;
    cycle(1, 1, 1, 0, '0);
    repeat (5) cycle(0, 1, 1, 0, '0);

    // Randomized traffic.
    lat_mode = -1;
    repeat (3000) begin
      r = ($urandom_range(199, 0) == 0);
      p = ($urandom_range(3, 0) != 0);
      w = p ? ($urandom_range(7, 0) != 0) : ($urandom_range(1, 0) == 1);
      f = ($urandom_range(11, 0) == 0);
      t = ($urandom_range(1, 0) == 1) ? $urandom() : (32'hFFFF_FFF0 | 32'($urandom_range(15, 0)));
      cycle(r, p, w, f, t);
    end

    #3;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
